// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared pixel widths, pixel bundle and scheduler state type
package draw_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int PIX_CNT_W = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR_RUN = 3'd1,
    CLR_REL = 3'd2,
    DRW_RUN = 3'd3,
    DRW_REL = 3'd4,
    FIN     = 3'd5
  } sched_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;
  } pixel_t;

endpackage

// File: rtl/vga_src_mux.sv
// rtl/vga_src_mux.sv - two-source pixel mux with source select and blanking
module vga_src_mux
  import draw_pkg::*;
(
  input  logic   sel_drw,
  input  logic   blank,
  input  pixel_t clr_pix,
  input  pixel_t drw_pix,
  output pixel_t vga_pix
);

  // Blanking forces every field to zero so no stray plot leaks out.
  always_comb begin
    vga_pix = '0;
    if (!blank) begin
      vga_pix = sel_drw ? drw_pix : clr_pix;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - clear-then-draw frame sequencer driving the VGA adapter
// Optional pixel counter output enabled by DRAW_SCHEDULER_PIXCNT_EN.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter logic [C_W-1:0] CLEAR_COLOUR = 3'b000,
  parameter int             AUTO_START   = 1
) (
`ifdef DRAW_SCHEDULER_PIXCNT_EN
  output logic [PIX_CNT_W-1:0] pix_count,
`endif
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  output logic           busy,
  output logic           frame_done,
  output logic           clr_start,
  output logic [C_W-1:0] clr_colour,
  input  logic           clr_done,
  input  logic [X_W-1:0] clr_x,
  input  logic [Y_W-1:0] clr_y,
  input  logic [C_W-1:0] clr_colour_in,
  input  logic           clr_plot,
  output logic           drw_start,
  input  logic           drw_done,
  input  logic [X_W-1:0] drw_x,
  input  logic [Y_W-1:0] drw_y,
  input  logic [C_W-1:0] drw_colour,
  input  logic           drw_plot,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  sched_state_t state, state_nxt;
  logic         pending;
  logic         start_frame;
  logic         in_seq;
  pixel_t       clr_pix, drw_pix, vga_pix;

  assign in_seq = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (go || pending) begin
          state_nxt   = CLR_RUN;
          start_frame = 1'b1;
        end
      end
      CLR_RUN: if (clr_done)  state_nxt = CLR_REL;
      CLR_REL: if (!clr_done) state_nxt = DRW_RUN;
      DRW_RUN: if (drw_done)  state_nxt = DRW_REL;
      DRW_REL: if (!drw_done) state_nxt = FIN;
      FIN:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // A single pending request is remembered; extra go pulses collapse into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= (AUTO_START != 0);
    end else begin
      state <= state_nxt;
      if (start_frame) begin
        pending <= 1'b0;
      end else if (go && in_seq) begin
        pending <= 1'b1;
      end
    end
  end

  // Outputs are gated by rst so nothing is asserted while reset is held.
  assign busy       = !rst && in_seq;
  assign frame_done = !rst && (state == FIN);
  assign clr_start  = !rst && (state == CLR_RUN);
  assign drw_start  = !rst && (state == DRW_RUN);
  assign clr_colour = CLEAR_COLOUR;

  assign clr_pix = '{x: clr_x, y: clr_y, colour: clr_colour_in, plot: clr_plot};
  assign drw_pix = '{x: drw_x, y: drw_y, colour: drw_colour, plot: drw_plot};

  vga_src_mux u_mux (
    .sel_drw (state == DRW_RUN),
    .blank   (rst || !((state == CLR_RUN) || (state == DRW_RUN))),
    .clr_pix (clr_pix),
    .drw_pix (drw_pix),
    .vga_pix (vga_pix)
  );

  assign vga_x      = vga_pix.x;
  assign vga_y      = vga_pix.y;
  assign vga_colour = vga_pix.colour;
  assign vga_plot   = vga_pix.plot;

`ifdef DRAW_SCHEDULER_PIXCNT_EN
  logic [PIX_CNT_W-1:0] pix_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start_frame) begin
      pix_cnt_q <= '0;
    end else if (vga_plot && (pix_cnt_q != {PIX_CNT_W{1'b1}})) begin
      pix_cnt_q <= pix_cnt_q + 1'b1;
    end
  end

  assign pix_count = pix_cnt_q;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - randomized and directed bench for draw_scheduler
module tb_draw_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, go = 1'b0;
  logic       clr_done = 1'b0, drw_done = 1'b0, clr_plot = 1'b0, drw_plot = 1'b0;
  logic [7:0] clr_x = '0, drw_x = '0;
  logic [6:0] clr_y = '0, drw_y = '0;
  logic [2:0] clr_colour_in = '0, drw_colour = '0;
  logic       busy, frame_done, clr_start, drw_start, vga_plot;
  logic [2:0] clr_colour, vga_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
`ifdef DRAW_SCHEDULER_PIXCNT_EN
  logic [14:0] pix_count;
`endif

  draw_scheduler #(.CLEAR_COLOUR(3'b000), .AUTO_START(1)) dut (
`ifdef DRAW_SCHEDULER_PIXCNT_EN
    .pix_count     (pix_count),
`endif
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .busy          (busy),
    .frame_done    (frame_done),
    .clr_start     (clr_start),
    .clr_colour    (clr_colour),
    .clr_done      (clr_done),
    .clr_x         (clr_x),
    .clr_y         (clr_y),
    .clr_colour_in (clr_colour_in),
    .clr_plot      (clr_plot),
    .drw_start     (drw_start),
    .drw_done      (drw_done),
    .drw_x         (drw_x),
    .drw_y         (drw_y),
    .drw_colour    (drw_colour),
    .drw_plot      (drw_plot),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fd_count = 0;

  typedef enum int {P_IDLE, P_CLEAR, P_CLEAR_WAIT, P_DRAW, P_DRAW_WAIT, P_FINISH} phase_t;
  phase_t m_phase = P_IDLE;
  bit     m_pend  = 1'b1;
  int     m_pix   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check this cycle against the model, advance the model across the edge.
  task automatic step();
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
    #1;
    ex = '0; ey = '0; ec = '0; ep = 1'b0;
    if (!rst && m_phase == P_CLEAR) begin
      ex = clr_x; ey = clr_y; ec = clr_colour_in; ep = clr_plot;
    end else if (!rst && m_phase == P_DRAW) begin
      ex = drw_x; ey = drw_y; ec = drw_colour; ep = drw_plot;
    end
    check_val("busy",       busy,       !rst && m_phase != P_IDLE);
    check_val("frame_done", frame_done, !rst && m_phase == P_FINISH);
    check_val("clr_start",  clr_start,  !rst && m_phase == P_CLEAR);
    check_val("drw_start",  drw_start,  !rst && m_phase == P_DRAW);
    check_val("clr_colour", clr_colour, 0);
    check_val("vga_plot",   vga_plot,   ep);
    check_val("vga_x",      vga_x,      ex);
    check_val("vga_y",      vga_y,      ey);
    check_val("vga_colour", vga_colour, ec);
`ifdef DRAW_SCHEDULER_PIXCNT_EN
    if (!rst) check_val("pix_count", pix_count, m_pix);
`endif
    if (frame_done === 1'b1) fd_count++;
    if (rst) begin
      m_phase = P_IDLE; m_pend = 1'b1; m_pix = 0;
    end else begin
      if (ep && m_pix < 32767) m_pix++;
      if (go && m_phase != P_IDLE) m_pend = 1'b1;
      case (m_phase)
        P_IDLE:       if (go || m_pend) begin m_phase = P_CLEAR; m_pend = 1'b0; m_pix = 0; end
        P_CLEAR:      if (clr_done)  m_phase = P_CLEAR_WAIT;
        P_CLEAR_WAIT: if (!clr_done) m_phase = P_DRAW;
        P_DRAW:       if (drw_done)  m_phase = P_DRAW_WAIT;
        P_DRAW_WAIT:  if (!drw_done) m_phase = P_FINISH;
        default:      m_phase = P_IDLE;
      endcase
    end
    @(negedge clk);
  endtask

  // Loose engine models: random latency, random release, occasional spurious done.
  task automatic drive_engines();
    if (clr_start)     clr_done = ($urandom % 4 == 0);
    else if (clr_done) clr_done = ($urandom % 2 == 0);
    else               clr_done = drw_start && ($urandom % 8 == 0);
    if (drw_start)     drw_done = ($urandom % 5 == 0);
    else if (drw_done) drw_done = ($urandom % 2 == 0);
    else               drw_done = 1'b0;
    clr_x = 8'($urandom); clr_y = 7'($urandom); clr_colour_in = 3'($urandom);
    drw_x = 8'($urandom); drw_y = 7'($urandom); drw_colour = 3'($urandom);
    clr_plot = 1'($urandom); drw_plot = 1'($urandom);
  endtask

  initial begin
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Auto-start timing, clear-source mux, three go pulses during draw
    for (int i = 0; i <= 12; i++) begin
      clr_done = (i == 5);
      drw_done = (i == 11);
      go       = (i == 8 || i == 9 || i == 10);
      clr_plot = 1'b0;
      drw_plot = 1'b0;
      if (i == 2) begin
        clr_x = 8'd10; clr_y = 7'd20; clr_colour_in = 3'b000; clr_plot = 1'b1;
        drw_x = 8'd99; drw_y = 7'd55; drw_colour = 3'b101;    drw_plot = 1'b1;
      end
      #1;
      check_val("r33_clr_start", clr_start, (i >= 1 && i <= 5));
      check_val("r33_drw_start", drw_start, (i >= 7 && i <= 11));
      if (i == 2) begin
        check_val("r34_vga_x", vga_x, 10);
        check_val("r34_vga_y", vga_y, 20);
        check_val("r34_vga_plot", vga_plot, 1);
        check_val("r34_vga_colour", vga_colour, 0);
      end
      step();
    end
    go = 1'b0;
    for (int k = 0; k < 300 && fd_count < 2; k++) begin
      drive_engines();
      step();
    end
    clr_done = 1'b0; drw_done = 1'b0; clr_plot = 1'b0; drw_plot = 1'b0;
    for (int k = 0; k < 20; k++) step();
    check_val("r35_frames", fd_count, 2);
    check_val("r35_idle", busy, 0);

    // Long clear done: held in release until it drops
    go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      clr_done = 1'b1;
      #1;
      if (k > 0) begin
        check_val("r37_hold_clr", clr_start, 0);
        check_val("r37_hold_drw", drw_start, 0);
        check_val("r37_hold_busy", busy, 1);
      end
      step();
    end
    clr_done = 1'b0;
    #1;
    check_val("r37_rel_drw", drw_start, 0);
    step();
    #1;
    check_val("r37_drw_after", drw_start, 1);

    // Reset mid-draw with the draw engine plotting
    drw_plot = 1'b1; drw_x = 8'd7;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_val("r36_drw_start", drw_start, 0);
    check_val("r36_busy", busy, 0);
    check_val("r36_vga_plot", vga_plot, 0);
    check_val("r36_frame_done", frame_done, 0);
    step();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      go  = ($urandom % 10 == 0);
      rst = ($urandom % 300 == 0);
      drive_engines();
      step();
    end
    go = 1'b0;
    rst = 1'b0;

`ifdef DRAW_SCHEDULER_PIXCNT_EN
    begin
      int nc, nd;
      bit seen;
      nc = 0; nd = 0; seen = 1'b0;
      rst = 1'b1; clr_done = 1'b0; drw_done = 1'b0; clr_plot = 1'b0; drw_plot = 1'b0;
      step();
      rst = 1'b0;
      for (int k = 0; k < 25000 && !seen; k++) begin
        clr_plot = clr_start && (nc < 19200);
        if (clr_plot) nc++;
        clr_done = clr_start && !clr_plot && (nc >= 19200);
        drw_plot = drw_start && (nd < 500);
        if (drw_plot) nd++;
        drw_done = drw_start && !drw_plot && (nd >= 500);
        #1;
        seen = (frame_done === 1'b1);
        step();
      end
      clr_plot = 1'b0; drw_plot = 1'b0; clr_done = 1'b0; drw_done = 1'b0;
      #1;
      check_val("r38_after_fin", pix_count, 19700);
      for (int k = 0; k < 5; k++) step();
      #1;
      check_val("r38_held", pix_count, 19700);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
